// File: rtl/bec_result_fifo.sv
// Result FIFO behind the bec core: captures {becStatus, data} on each rising done and drains over Wishbone.
// Optional BEC_FIFO_IRQ_EN adds a writable THRESH register and a level interrupt.
module bec_result_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        slv_done,
  input  logic [3:0]  becStatus,
  input  logic [31:0] data_in,
  output logic        irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [35:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, done_q, ack;
  logic [31:0]   dat_q, rdata, status_word;
  logic [35:0]   head;
  logic [1:0]    reg_idx;
  logic          req, rd_req, wr_req;
  logic          empty, full;
  logic          push, pop, push_ok, drop, flush, clr_ov;
  logic          unused_ok;

  assign reg_idx = wbs_adr_i[3:2];
  assign req     = wbs_stb_i & wbs_cyc_i & ~ack & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign rd_req  = req & ~wbs_we_i;
  assign wr_req  = req & wbs_we_i;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];

  assign push    = slv_done & ~done_q;
  assign pop     = rd_req & (reg_idx == 2'd0) & ~empty;
  assign flush   = wr_req & (reg_idx == 2'd2) & wbs_sel_i[0] & wbs_dat_i[0];
  assign clr_ov  = wr_req & (reg_idx == 2'd2) & wbs_sel_i[0] & wbs_dat_i[1];
  // A same-cycle pop frees the slot, so a push into a full FIFO only drops when nothing leaves.
  assign push_ok = push & ~flush & (~full | pop);
  assign drop    = push & ~flush & full & ~pop;

  assign status_word = {22'b0, overflow, full, empty, 1'b0, 6'(count)};

  always_comb begin
    rdata = '0;
    case (reg_idx)
      2'd0:    rdata = empty ? '0 : head[31:0];
      2'd1:    rdata = status_word;
      2'd3:    rdata = empty ? '0 : {28'b0, head[35:32]};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= {becStatus, data_in};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done_q   <= 1'b0;
      ack      <= 1'b0;
      dat_q    <= '0;
    end else begin
      done_q <= slv_done;
      ack    <= req;
      dat_q  <= rd_req ? rdata : '0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (drop)        overflow <= 1'b1;
      else if (clr_ov) overflow <= 1'b0;
    end
  end

  assign wbs_ack_o = ack;
  assign wbs_dat_o = dat_q;

`ifdef BEC_FIFO_IRQ_EN
  logic [CW-1:0] thresh;
  logic          irq_q;
  logic          thresh_wr;

  assign thresh_wr = wr_req & (reg_idx == 2'd3) & wbs_sel_i[0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      thresh <= {{(CW-1){1'b0}}, 1'b1};
      irq_q  <= 1'b0;
    end else begin
      if (thresh_wr)
        thresh <= (wbs_dat_i[CW-1:0] == '0) ? {{(CW-1){1'b0}}, 1'b1} : wbs_dat_i[CW-1:0];
      irq_q <= (count >= thresh) | overflow;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign unused_ok = &{1'b0, wbs_sel_i, wbs_dat_i, wbs_adr_i[1:0]};

endmodule

// File: tb/tb_bec_result_fifo.sv
// Directed + randomized bench for bec_result_fifo; expectations come from a queue-based model.
module tb_bec_result_fifo;

  localparam logic [31:0] BASE   = 32'h3000_0100;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_TAG  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack;
  logic [31:0] rdat;
  logic        slv_done;
  logic [3:0]  bec_status;
  logic [31:0] data_in;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [35:0] q[$];
  logic        ov;
  int          thr;

  bec_result_fifo #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(wdat),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .slv_done (slv_done),
    .becStatus(bec_status),
    .data_in  (data_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {22'b0, ov, (q.size() == DEPTH), (q.size() == 0), 1'b0, 6'(q.size())};
  endfunction

  function automatic logic model_irq();
`ifdef BEC_FIFO_IRQ_EN
    return (q.size() >= thr) || ov;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_irq(input string tag);
    chk({tag, "_irq"}, {31'b0, irq}, {31'b0, model_irq()});
  endtask

  task automatic model_reset();
    q.delete();
    ov  = 1'b0;
    thr = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; wdat = '0; adr = '0;
    slv_done = 1'b0; bec_status = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  // done held for `hold` cycles, then low for one so the next call is a fresh edge
  task automatic do_push(input logic [31:0] d, input logic [3:0] st, input int hold, input string tag);
    data_in = d; bec_status = st; slv_done = 1'b1;
    repeat (hold) @(posedge clk);
    #1 slv_done = 1'b0;
    @(posedge clk); #1;
    if (q.size() < DEPTH) q.push_back({st, d});
    else ov = 1'b1;
    chk_irq(tag);
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] s, input bit with_push, input logic [35:0] pent,
                         input string tag);
    logic [31:0] exp;
    logic [1:0]  idx;
    bit          flushed;
    idx = a[3:2];
    exp = '0;
    flushed = 1'b0;
    if (!w) begin
      case (idx)
        2'd0: if (q.size() > 0) exp = q[0][31:0];
        2'd1: exp = model_status();
        2'd3: if (q.size() > 0) exp = {28'b0, q[0][35:32]};
        default: exp = '0;
      endcase
      if (idx == 2'd0 && q.size() > 0) void'(q.pop_front());
    end else if (s[0]) begin
      if (idx == 2'd2) begin
        if (wd[0]) begin q.delete(); flushed = 1'b1; end
        if (wd[1]) ov = 1'b0;
      end
`ifdef BEC_FIFO_IRQ_EN
      if (idx == 2'd3) thr = (wd[3:0] == 4'd0) ? 1 : int'(wd[3:0]);
`endif
    end
    if (with_push && !flushed) begin
      if (q.size() < DEPTH) q.push_back(pent);
      else ov = 1'b1;
    end

    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = wd; sel = s;
    if (with_push) begin
      bec_status = pent[35:32]; data_in = pent[31:0]; slv_done = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
    chk({tag, "_dat"}, rdat, exp);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; slv_done = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ackdrop"}, {31'b0, ack}, 32'd0);
    chk({tag, "_datidle"}, rdat, 32'd0);
    chk_irq(tag);
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    wb_xfer(a, 1'b0, '0, 4'h0, 1'b0, '0, tag);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    wb_xfer(a, 1'b1, d, 4'hF, 1'b0, '0, tag);
  endtask

  initial begin
    bit seen_ack;
    int op;
    logic [31:0] r;

    do_reset();
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);

    rd(A_STAT, "empty_status");
    rd(A_DATA, "empty_data");
    rd(A_STAT, "empty_status2");

    do_push(32'hCAFE_0001, 4'h5, 3, "held_done");
    rd(A_STAT, "one_status");
    rd(A_TAG,  "one_tag");
    rd(A_DATA, "one_data");
    rd(A_STAT, "one_status_after");

    for (int i = 1; i <= 9; i++) do_push(32'(i), 4'(i), 1, "fill9");
    rd(A_STAT, "ovf_status");
    for (int i = 0; i < 8; i++) rd(A_DATA, "drain8");
    wr(A_CTRL, 32'h2, "clr_ov");
    rd(A_STAT, "clr_ov_status");

    for (int i = 0; i < 8; i++) do_push(32'h100 + 32'(i), 4'(i), 1, "fill8");
    wb_xfer(A_DATA, 1'b0, '0, 4'h0, 1'b1, {4'h9, 32'hBEEF_0009}, "full_pop_push");
    rd(A_STAT, "full_pop_push_status");
    for (int i = 0; i < 8; i++) rd(A_DATA, "drain_after_pp");

    for (int i = 0; i < 3; i++) do_push(32'h200 + 32'(i), 4'hA, 2, "fill3");
    wb_xfer(A_CTRL, 1'b1, 32'h1, 4'h1, 1'b1, {4'hB, 32'hDEAD_0003}, "flush_push");
    rd(A_STAT, "flush_status");

`ifdef BEC_FIFO_IRQ_EN
    wr(A_TAG, 32'd2, "thresh2");
    chk("irq_thr_empty", {31'b0, irq}, 32'd0);
    do_push(32'h300, 4'h1, 1, "irq_push1");
    chk("irq_after_1", {31'b0, irq}, 32'd0);
    do_push(32'h301, 4'h2, 1, "irq_push2");
    chk("irq_after_2", {31'b0, irq}, 32'd1);
    rd(A_DATA, "irq_pop");
    chk("irq_after_pop", {31'b0, irq}, 32'd0);
    wr(A_TAG, 32'd0, "thresh0");
    chk("irq_thr_coerced", {31'b0, irq}, 32'd1);
    wr(A_CTRL, 32'h1, "irq_flush");
`endif

    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0200; sel = 4'hF;
    seen_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) seen_ack = 1'b1;
    end
    chk("oow_no_ack", {31'b0, seen_ack}, 32'd0);
    chk("oow_dat", rdat, 32'd0);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 7);
      r  = $urandom;
      if (op <= 2) begin
        do_push(r, 4'($urandom), $urandom_range(1, 3), "rnd_push");
      end else if (op <= 4) begin
        rd(BASE | {26'b0, 2'($urandom), 2'($urandom)}, "rnd_read");
      end else if (op == 5) begin
        if ($urandom_range(0, 3) != 0) r[0] = 1'b0;
        wb_xfer(BASE | {26'b0, 2'($urandom), 2'b00}, 1'b1, r, 4'($urandom), 1'b0, '0, "rnd_write");
      end else begin
        wb_xfer(A_DATA, 1'b0, '0, 4'h0, 1'b1, {4'($urandom), r}, "rnd_pop_push");
      end
    end

    do_push(32'h0000_AAAA, 4'h3, 1, "pre_rst_push");
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_STAT; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ack", {31'b0, ack}, 32'd0);
    chk("midrst_dat", rdat, 32'd0);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    rd(A_STAT, "midrst_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bec_result_fifo.md
Name: bec_result_fifo

Overview:
- Downstream consumer of the bec core.
- Captures each 32-bit result word and its 4-bit status when the core signals done, and buffers them in a small FIFO.
- Exposes the FIFO to the management SoC as a Wishbone slave, so firmware can drain results without LA polling.
- Sits in user_project_wrapper beside lovers_controller, on the bec data_out/done/becStatus nets.

Parameters:
- BASE_ADDR, 32'h3000_0100, Wishbone base address; window is 16 bytes, decoded on adr[31:4].
- DEPTH, 8, FIFO entries. Must be a power of two, 2..32. Pointer width is log2(DEPTH); the count field is log2(DEPTH)+1 bits.

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; only sel[0] is honoured on writes.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data; 0 whenever ack is low.
- slv_done  in  1  bec done level.
- becStatus  in  4  bec status, captured together with the data word.
- data_in  in  32  bec data_out.
- irq  out  1  FIFO-level interrupt; see Optional Feature.

Behaviour:
- Reset: all outputs 0; rd_ptr = wr_ptr = count = 0; overflow = 0; done_q = 0; thresh = 1. FIFO RAM contents are don't-care.
- Capture:
  - push = slv_done & ~done_q, a rising-edge detect; done_q registers slv_done.
  - On push, store {becStatus, data_in} at wr_ptr and increment wr_ptr (wraps mod DEPTH).
  - A done held high pushes exactly once.
- Full (count == DEPTH):
  - A push is dropped; pointers and count are unchanged.
  - overflow sticky is set on the following cycle.
- Wishbone request: req = stb & cyc & ~ack & (adr[31:4] == BASE_ADDR[31:4]).
  - ack is asserted on the cycle after req and held for exactly one cycle.
  - No back-to-back acks.
  - Out-of-window addresses are never acked.
- Register map (adr[3:2]):
  - 0 DATA (RO): head data word.
    - If count > 0, the read pops on the ack cycle.
    - If empty, returns 0 and does not pop.
  - 1 STATUS (RO): {22'b0, overflow[9], full[8], empty[7], 1'b0, count[5:0]}, with count zero-extended.
  - 2 CTRL (WO, requires sel[0]):
    - bit0: flush (pointers and count to 0).
    - bit1: clear overflow.
    - Reads return 0.
  - 3 HEAD_TAG (RO): {28'b0, becStatus of head entry}; 0 if empty. Does not pop.
- Writes to RO registers are acked and ignored.
- Read data is registered and launched with ack, so read latency is 1 cycle after req.
- Simultaneous events:
  - push + pop in the same cycle: both happen, count unchanged.
  - push + pop while full: the pop frees a slot, so the push is accepted and overflow is not set.
  - pop while empty with a same-cycle push: the read returns 0, and the push lands.
  - flush + push: flush wins, the push is discarded, overflow is unaffected.
  - flush + clear-overflow in the same write: both take effect.
- A reset asserted mid-transaction aborts any pending ack next cycle; all state returns to reset values.

Optional Feature:
- Macro BEC_FIFO_IRQ_EN.
- When defined:
  - adr[3:2]=3 becomes HEAD_TAG on read and THRESH on write. THRESH is a (log2(DEPTH)+1)-bit register written from dat_i, reset value 1; writes of 0 are coerced to 1.
  - irq is registered: irq = (count >= thresh) | overflow, updated every cycle.
- When undefined: irq is tied to 0; writes to adr[3:2]=3 are acked and ignored.

Test Plan:
- Reset, then read STATUS: dat = 32'h0000_0080 (empty). Read DATA: 0, count stays 0.
- Drive slv_done high for 3 cycles with data_in = 32'hCAFE_0001, becStatus = 4'h5: STATUS count = 1. HEAD_TAG = 5. DATA = 32'hCAFE_0001. STATUS then = 32'h80.
- Issue 9 done pulses with data 1..9 (DEPTH = 8): STATUS = 32'h0000_0308 (overflow, full, count 8). Eight DATA reads return 1..8. Write CTRL = 2: overflow clears.
- With 8 entries held, issue a done pulse on the same cycle as a DATA pop ack: pop returns the head, the new word is accepted, count stays 8, overflow = 0.
- Fill with 3 entries, write CTRL = 1 in the same cycle as a done pulse: count = 0, empty = 1, overflow = 0.
- (BEC_FIFO_IRQ_EN) Write THRESH = 2: irq = 0 after 1 push, irq = 1 after the 2nd push. One DATA read drops irq the next cycle. Access at 0x3000_0200 never gets an ack.
